// File: rtl/io_uart_pkg.sv
//==============================================================================
// Module : io_uart_pkg
// Register offsets, STATUS bit positions and TX FSM encoding for io_uart_tx.
// Optional build macro: UART_TX_PARITY_EN (adds the PARITY state).
// Rev    : 1.0
//==============================================================================
`default_nettype none

package io_uart_pkg;

  localparam int TXDATA_OFS = 0;
  localparam int STATUS_OFS = 1;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 4;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;
`endif

endpackage

`default_nettype wire

// File: rtl/io_uart_fifo.sv
//==============================================================================
// Module : io_uart_fifo
// 8-bit synchronous FIFO with combinational head; pushes when full are dropped.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module io_uart_fifo
  import io_uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int c_depth = 2 ** DEPTH_LOG2;

  logic [7:0]            r_mem [c_depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  // Full/empty are judged on the pre-edge count, so a push into a full FIFO
  // is lost even when a pop happens in the same cycle.
  assign full      = (r_count == (DEPTH_LOG2 + 1)'(c_depth));
  assign empty     = (r_count == '0);
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;
  assign rdata     = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/io_uart_tx.sv
//==============================================================================
// Module : io_uart_tx
// Memory-mapped UART transmitter (TXDATA/STATUS) serialising a TX FIFO as 8N1.
// Optional build macro: UART_TX_PARITY_EN (8E1 framing).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module io_uart_tx
  import io_uart_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 16,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR       = 16'hC000,
  parameter int                    CLKS_PER_BIT    = 217,
  parameter int                    FIFO_DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] io_addr,
  input  logic                  io_write,
  input  logic [DATA_WIDTH-1:0] io_wr_data,
  output logic [DATA_WIDTH-1:0] io_rd_data,
  output logic                  uart_tx,
  output logic                  tx_busy
);

  localparam int c_cnt_w  = FIFO_DEPTH_LOG2 + 1;
  localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_baud_w-1:0]   c_baud_last   = c_baud_w'(CLKS_PER_BIT - 1);
  localparam logic [DATA_WIDTH-1:0] c_txdata_addr = DATA_WIDTH'(BASE_ADDR + TXDATA_OFS);
  localparam logic [DATA_WIDTH-1:0] c_status_addr = DATA_WIDTH'(BASE_ADDR + STATUS_OFS);

  uart_state_e          r_state, w_state_next;
  logic [c_baud_w-1:0]  r_baud, w_baud_next;
  logic [2:0]           r_bit_idx, w_bit_idx_next;
  logic [7:0]           r_shift, w_shift_next;
  logic                 r_tx, w_tx_next;
  logic                 r_ovf;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity, w_parity_next;
`endif

  logic                 w_sel_data, w_sel_status;
  logic                 w_push, w_pop, w_full, w_empty, w_baud_term;
  logic [7:0]           w_head;
  logic [c_cnt_w-1:0]   w_count;
  logic [DATA_WIDTH-1:0] w_status;
  logic                 w_unused_wr_data;

  assign w_sel_data       = (io_addr == c_txdata_addr);
  assign w_sel_status     = (io_addr == c_status_addr);
  assign w_push           = io_write & w_sel_data;
  assign w_pop            = (r_state == ST_IDLE) & ~w_empty;
  assign w_baud_term      = (r_baud == c_baud_last);
  assign w_unused_wr_data = ^io_wr_data[DATA_WIDTH-1:8];

  io_uart_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .wdata   (io_wr_data[7:0]),
    .rdata   (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  always_comb begin
    w_status                               = '0;
    w_status[STAT_FULL]                    = w_full;
    w_status[STAT_EMPTY]                   = w_empty;
    w_status[STAT_BUSY]                    = tx_busy;
    w_status[STAT_OVF]                     = r_ovf;
    w_status[STAT_COUNT_LSB +: c_cnt_w]    = w_count;
  end

  // The CPU latches read data on the same edge as the load, so no register here.
  assign io_rd_data = w_sel_status ? w_status : '0;
  assign uart_tx    = r_tx;
  assign tx_busy    = (r_state != ST_IDLE) | ~w_empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full) begin
      r_ovf <= 1'b1;
    end else if (io_write && w_sel_status) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parity_next;
`endif
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_baud_next    = w_baud_term ? '0 : r_baud + c_baud_w'(1);
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_tx_next      = r_tx;
`ifdef UART_TX_PARITY_EN
    w_parity_next  = r_parity;
`endif
    case (r_state)
      ST_IDLE: begin
        w_baud_next = '0;
        w_tx_next   = 1'b1;
        if (!w_empty) begin
          w_shift_next = w_head;
          w_tx_next    = 1'b0;
          w_state_next = ST_START;
`ifdef UART_TX_PARITY_EN
          w_parity_next = ^w_head;
`endif
        end
      end
      ST_START: begin
        if (w_baud_term) begin
          w_tx_next      = r_shift[0];
          w_bit_idx_next = '0;
          w_state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_baud_term) begin
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_tx_next    = r_parity;
            w_state_next = ST_PARITY;
`else
            w_tx_next    = 1'b1;
            w_state_next = ST_STOP;
`endif
          end else begin
            // Shift right so the next data bit is always at [0] after the edge.
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_tx_next      = r_shift[1];
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_baud_term) begin
          w_tx_next    = 1'b1;
          w_state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_baud_term) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_tx_next    = 1'b1;
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_io_uart_tx.sv
//==============================================================================
// Module : tb_io_uart_tx
// Directed self-checking bench for io_uart_tx (CLKS_PER_BIT=4, 8-deep FIFO).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_io_uart_tx;

  localparam int c_cpb = 4;
`ifdef UART_TX_PARITY_EN
  localparam int c_slots = 11;
`else
  localparam int c_slots = 10;
`endif

  logic        clock;
  logic        reset_n;
  logic [15:0] io_addr;
  logic        io_write;
  logic [15:0] io_wr_data;
  logic [15:0] io_rd_data;
  logic        uart_tx;
  logic        tx_busy;

  int n_vec;
  int n_err;
  int cyc;

  io_uart_tx #(
    .DATA_WIDTH      (16),
    .BASE_ADDR       (16'hC000),
    .CLKS_PER_BIT    (c_cpb),
    .FIFO_DEPTH_LOG2 (3)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .io_addr    (io_addr),
    .io_write   (io_write),
    .io_wr_data (io_wr_data),
    .io_rd_data (io_rd_data),
    .uart_tx    (uart_tx),
    .tx_busy    (tx_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    io_addr    = a;
    io_wr_data = d;
    io_write   = 1'b1;
    tick();
    io_write   = 1'b0;
  endtask

  // Starts on the first start-bit sample; ends on the sample after the stop bit.
  task automatic watch_frame(input logic [7:0] data, output int bad, output logic [7:0] got);
    logic exp;
    int   slot;
    bad = 0;
    got = '0;
    for (int k = 0; k < c_slots * c_cpb; k++) begin
      slot = k / c_cpb;
      if (slot == 0)                exp = 1'b0;
      else if (slot <= 8)           exp = data[slot-1];
      else if (slot == c_slots - 1) exp = 1'b1;
      else                          exp = ^data;
      if (uart_tx !== exp) bad++;
      if (slot >= 1 && slot <= 8 && (k % c_cpb) == 2) got[slot-1] = uart_tx;
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    io_addr = 16'hC001; #1;
    n_vec++; if (io_rd_data !== 16'h0002) begin n_err++; $display("FAIL reset_status got %h want %h", io_rd_data, 16'h0002); end
    n_vec++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL reset_tx got %b want 1", uart_tx); end
    n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", tx_busy); end
    io_addr = 16'hC000; #1;
    n_vec++; if (io_rd_data !== 16'h0000) begin n_err++; $display("FAIL txdata_read got %h want 0000", io_rd_data); end
    io_addr = 16'hC005; #1;
    n_vec++; if (io_rd_data !== 16'h0000) begin n_err++; $display("FAIL other_read got %h want 0000", io_rd_data); end
    bus_write(16'hC002, 16'h00AA);
    tick();
    io_addr = 16'hC001; #1;
    n_vec++; if (io_rd_data !== 16'h0002 || uart_tx !== 1'b1) begin
      n_err++; $display("FAIL other_write status %h tx %b want 0002 tx 1", io_rd_data, uart_tx);
    end
  endtask

  task automatic test_single();
    int bad; logic [7:0] got;
    bus_write(16'hC000, 16'hFF55);
    io_addr = 16'hC001; #1;
    n_vec++; if (io_rd_data !== 16'h0014 || uart_tx !== 1'b1) begin
      n_err++; $display("FAIL single_queued status %h tx %b want 0014 tx 1", io_rd_data, uart_tx);
    end
    tick();
    watch_frame(8'h55, bad, got);
    n_vec++; if (bad !== 0 || got !== 8'h55) begin
      n_err++; $display("FAIL single_frame bad_clocks %0d byte %h want 0 byte 55", bad, got);
    end
    n_vec++; if (tx_busy !== 1'b0 || uart_tx !== 1'b1) begin
      n_err++; $display("FAIL single_done busy %b tx %b want busy 0 tx 1", tx_busy, uart_tx);
    end
  endtask

  task automatic test_fifo_overflow();
    int bad; int c1; logic [7:0] got;
    bus_write(16'hC000, 16'h0001);
    c1 = cyc;
    for (int i = 2; i <= 9; i++) bus_write(16'hC000, 16'(i));
    io_addr = 16'hC001; #1;
    n_vec++; if (io_rd_data !== 16'h0085) begin n_err++; $display("FAIL fifo_full status got %h want 0085", io_rd_data); end
    for (int i = 0; i < 9; i++) bus_write(16'hC000, 16'(8'hE0 + i));
    io_addr = 16'hC001; #1;
    n_vec++; if (io_rd_data !== 16'h008D) begin n_err++; $display("FAIL fifo_ovf status got %h want 008d", io_rd_data); end
    bus_write(16'hC001, 16'h0000);
    io_addr = 16'hC001; #1;
    n_vec++; if (io_rd_data !== 16'h0085) begin n_err++; $display("FAIL ovf_clear status got %h want 0085", io_rd_data); end
    while (cyc < c1 + 1 + (c_slots * c_cpb + 1)) tick();
    for (int i = 2; i <= 9; i++) begin
      watch_frame(8'(i), bad, got);
      n_vec++; if (bad !== 0 || got !== 8'(i)) begin
        n_err++; $display("FAIL drain_frame bad_clocks %0d byte %h want 0 byte %h", bad, got, 8'(i));
      end
      n_vec++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL drain_idle tx got %b want 1", uart_tx); end
      tick();
    end
    n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL drain_done busy got %b want 0", tx_busy); end
  endtask

  task automatic test_back_to_back();
    int bad; logic [7:0] got;
    bus_write(16'hC000, 16'h00A5);
    bus_write(16'hC000, 16'h003C);
    watch_frame(8'hA5, bad, got);
    n_vec++; if (bad !== 0 || got !== 8'hA5) begin
      n_err++; $display("FAIL b2b_first bad_clocks %0d byte %h want 0 byte a5", bad, got);
    end
    n_vec++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL b2b_gap tx got %b want 1", uart_tx); end
    tick();
    watch_frame(8'h3C, bad, got);
    n_vec++; if (bad !== 0 || got !== 8'h3C) begin
      n_err++; $display("FAIL b2b_second bad_clocks %0d byte %h want 0 byte 3c", bad, got);
    end
    n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL b2b_done busy got %b want 0", tx_busy); end
  endtask

  task automatic test_reset_mid_frame();
    int r; int lows;
    bus_write(16'hC000, 16'h000F);
    r = cyc;
    while (cyc < r + 22) tick();
    n_vec++; if (uart_tx !== 1'b0) begin n_err++; $display("FAIL mid_bit4 tx got %b want 0", uart_tx); end
    reset_n = 1'b0;
    #1;
    n_vec++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL async_reset tx got %b want 1", uart_tx); end
    tick(); tick();
    reset_n = 1'b1;
    io_addr = 16'hC001; #1;
    n_vec++; if (io_rd_data !== 16'h0002) begin n_err++; $display("FAIL post_reset status got %h want 0002", io_rd_data); end
    lows = 0;
    for (int i = 0; i < 50; i++) begin tick(); if (uart_tx !== 1'b1 || tx_busy !== 1'b0) lows++; end
    n_vec++; if (lows !== 0) begin n_err++; $display("FAIL no_resume active_clocks %0d want 0", lows); end
  endtask

  task automatic test_parity();
    int bad; int len; logic [7:0] got;
    bus_write(16'hC000, 16'h0007);
    tick();
    watch_frame(8'h07, bad, got);
    n_vec++; if (bad !== 0 || got !== 8'h07) begin
      n_err++; $display("FAIL parity_frame bad_clocks %0d byte %h want 0 byte 07", bad, got);
    end
    len = c_slots * c_cpb;
    n_vec++; if (tx_busy !== 1'b0) begin
      n_err++; $display("FAIL frame_len busy %b after %0d clocks want 0", tx_busy, len);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    reset_n = 1'b0; io_addr = '0; io_write = 1'b0; io_wr_data = '0;
    test_reset();
    test_single();
    test_fifo_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
